fft_bfly_seq: RTL and testbench

- Radix-2 decimation-in-time butterfly sequencer: accepts one complex pair A, B and a twiddle W, and produces X = A + W·B and Y = A − W·B.
- Computes the four Q1.15 twiddle products on a single internal multiplier.
- Issues all add/sub work, one operation per cycle, to the shared combinational fft_alu through alu_mode/operand outputs, and captures the ALU result in the same cycle.
- Sits between the FFT memory/address controller (upstream) and fft_alu; results return to the controller for write-back.

---
 rtl/fft_bfly_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_fft_bfly_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_seq.sv
// rtl/fft_bfly_seq.sv - radix-2 DIT butterfly sequencer driving a shared fft_alu

`ifndef ALUMODE_IDLE
`define ALUMODE_IDLE 4'd0
`endif
`ifndef ALUMODE_A_ADD_B
`define ALUMODE_A_ADD_B 4'd1
`endif
`ifndef ALUMODE_A_SUB_B
`define ALUMODE_A_SUB_B 4'd2
`endif

module fft_bfly_seq #(
    parameter bit SAT_MUL = 1'b1,
    parameter bit CONJ_TW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] a_re_i,
    input  logic [15:0] a_im_i,
    input  logic [15:0] b_re_i,
    input  logic [15:0] b_im_i,
    input  logic [15:0] w_re_i,
    input  logic [15:0] w_im_i,
    output logic [15:0] alu_op_a_o,
    output logic [15:0] alu_op_b_o,
    output logic [15:0] alu_op_c_o,
    output logic [3:0]  alu_mode_o,
    input  logic [15:0] alu_res_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] x_re_o,
    output logic [15:0] x_im_o,
    output logic [15:0] y_re_o,
    output logic [15:0] y_im_o
);

    localparam logic [3:0] MODE_IDLE = `ALUMODE_IDLE;
    localparam logic [3:0] MODE_ADD  = `ALUMODE_A_ADD_B;
    localparam logic [3:0] MODE_SUB  = `ALUMODE_A_SUB_B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ALU  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [15:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
    logic [15:0] p_q [4];
    logic [15:0] tr_q, ti_q;
    logic [15:0] x_re_q, x_im_q, y_re_q, y_im_q;

    logic               accept;
    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] prod;
    logic [15:0]        prod_q15;

    assign accept = (state_q == S_IDLE) && in_valid_i;

    // State and step counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencing: 4 multiply steps, 6 ALU steps, then hold result until taken
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_o = 1'b1;
                cnt_d      = 3'd0;
                if (in_valid_i) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == 3'd3) begin
                    state_d = S_ALU;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_ALU: begin
                if (cnt_q == 3'd5) begin
                    state_d = S_DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Capture operands on the request handshake only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_re_q <= 16'd0;
            a_im_q <= 16'd0;
            b_re_q <= 16'd0;
            b_im_q <= 16'd0;
            w_re_q <= 16'd0;
            w_im_q <= 16'd0;
        end else if (accept) begin
            a_re_q <= a_re_i;
            a_im_q <= a_im_i;
            b_re_q <= b_re_i;
            b_im_q <= b_im_i;
            w_re_q <= w_re_i;
            w_im_q <= w_im_i;
        end
    end

    // Single shared multiplier: operand pair chosen by the MUL step
    always_comb begin
        mul_a = $signed(b_re_q);
        mul_b = $signed(w_re_q);
        case (cnt_q[1:0])
            2'd0: begin mul_a = $signed(b_re_q); mul_b = $signed(w_re_q); end
            2'd1: begin mul_a = $signed(b_im_q); mul_b = $signed(w_im_q); end
            2'd2: begin mul_a = $signed(b_re_q); mul_b = $signed(w_im_q); end
            default: begin mul_a = $signed(b_im_q); mul_b = $signed(w_re_q); end
        endcase
    end

    assign prod = mul_a * mul_b;

    // Q15 rescale; only -1 * -1 overflows, giving 2^30
    always_comb begin
        prod_q15 = prod[30:15];
        if (SAT_MUL && (prod == 32'sh4000_0000)) begin
            prod_q15 = 16'h7FFF;
        end
    end

    // Product registers p0..p3, one per MUL step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                p_q[i] <= 16'd0;
            end
        end else if (state_q == S_MUL) begin
            p_q[cnt_q[1:0]] <= prod_q15;
        end
    end

    // ALU request per step; idle mode and zero operands outside the ALU phase
    always_comb begin
        alu_mode_o = MODE_IDLE;
        alu_op_a_o = 16'd0;
        alu_op_b_o = 16'd0;
        alu_op_c_o = 16'd0;
        if (state_q == S_ALU) begin
            case (cnt_q)
                3'd0: begin
                    alu_mode_o = CONJ_TW ? MODE_ADD : MODE_SUB;
                    alu_op_a_o = p_q[0];
                    alu_op_b_o = p_q[1];
                end
                3'd1: begin
                    alu_mode_o = CONJ_TW ? MODE_SUB : MODE_ADD;
                    alu_op_a_o = CONJ_TW ? p_q[3] : p_q[2];
                    alu_op_b_o = CONJ_TW ? p_q[2] : p_q[3];
                end
                3'd2: begin
                    alu_mode_o = MODE_ADD;
                    alu_op_a_o = a_re_q;
                    alu_op_b_o = tr_q;
                end
                3'd3: begin
                    alu_mode_o = MODE_ADD;
                    alu_op_a_o = a_im_q;
                    alu_op_b_o = ti_q;
                end
                3'd4: begin
                    alu_mode_o = MODE_SUB;
                    alu_op_a_o = a_re_q;
                    alu_op_b_o = tr_q;
                end
                3'd5: begin
                    alu_mode_o = MODE_SUB;
                    alu_op_a_o = a_im_q;
                    alu_op_b_o = ti_q;
                end
                default: begin
                    alu_mode_o = MODE_IDLE;
                end
            endcase
        end
    end

    // Capture the combinational ALU result in the same cycle it is requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tr_q   <= 16'd0;
            ti_q   <= 16'd0;
            x_re_q <= 16'd0;
            x_im_q <= 16'd0;
            y_re_q <= 16'd0;
            y_im_q <= 16'd0;
        end else if (state_q == S_ALU) begin
            case (cnt_q)
                3'd0:    tr_q   <= alu_res_i;
                3'd1:    ti_q   <= alu_res_i;
                3'd2:    x_re_q <= alu_res_i;
                3'd3:    x_im_q <= alu_res_i;
                3'd4:    y_re_q <= alu_res_i;
                3'd5:    y_im_q <= alu_res_i;
                default: tr_q   <= tr_q;
            endcase
        end
    end

    assign x_re_o = x_re_q;
    assign x_im_o = x_im_q;
    assign y_re_o = y_re_q;
    assign y_im_o = y_im_q;

endmodule

// File: tb/tb_fft_bfly_seq.sv
// tb/tb_fft_bfly_seq.sv - scoreboard bench for fft_bfly_seq (two parameter sets)

`ifndef ALUMODE_IDLE
`define ALUMODE_IDLE 4'd0
`endif
`ifndef ALUMODE_A_ADD_B
`define ALUMODE_A_ADD_B 4'd1
`endif
`ifndef ALUMODE_A_SUB_B
`define ALUMODE_A_SUB_B 4'd2
`endif

module tb_fft_bfly_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;

    logic        rdy0, rdy1, ov0, ov1;
    logic [15:0] opa0, opb0, opc0, opa1, opb1, opc1, res0, res1;
    logic [3:0]  mode0, mode1;
    logic [15:0] xr0, xi0, yr0, yi0, xr1, xi1, yr1, yi1;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clk = ~clk;

    // Reference fft_alu behaviour for each instance
    always_comb begin
        res0 = 16'd0;
        if (mode0 == `ALUMODE_A_ADD_B) res0 = opa0 + opb0;
        else if (mode0 == `ALUMODE_A_SUB_B) res0 = opa0 - opb0;
    end
    always_comb begin
        res1 = 16'd0;
        if (mode1 == `ALUMODE_A_ADD_B) res1 = opa1 + opb1;
        else if (mode1 == `ALUMODE_A_SUB_B) res1 = opa1 - opb1;
    end

    fft_bfly_seq #(.SAT_MUL(1'b1), .CONJ_TW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy0),
        .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
        .w_re_i(w_re), .w_im_i(w_im),
        .alu_op_a_o(opa0), .alu_op_b_o(opb0), .alu_op_c_o(opc0), .alu_mode_o(mode0),
        .alu_res_i(res0), .out_valid_o(ov0), .out_ready_i(out_ready),
        .x_re_o(xr0), .x_im_o(xi0), .y_re_o(yr0), .y_im_o(yi0)
    );

    fft_bfly_seq #(.SAT_MUL(1'b0), .CONJ_TW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
        .w_re_i(w_re), .w_im_i(w_im),
        .alu_op_a_o(opa1), .alu_op_b_o(opb1), .alu_op_c_o(opc1), .alu_mode_o(mode1),
        .alu_res_i(res1), .out_valid_o(ov1), .out_ready_i(out_ready),
        .x_re_o(xr1), .x_im_o(xi1), .y_re_o(yr1), .y_im_o(yi1)
    );

    function automatic logic [15:0] mq(input logic signed [15:0] b, input logic signed [15:0] w,
                                       input bit sat);
        longint p;
        p = longint'(b) * longint'(w);
        if (sat && p == 64'sd1073741824) return 16'h7FFF;
        return 16'(p >>> 15);
    endfunction

    function automatic logic [63:0] bfly(input logic [15:0] ar, ai, br, bi, wr, wi,
                                         input bit sat, input bit conj);
        logic [15:0] p0, p1, p2, p3, tr, ti;
        p0 = mq(br, wr, sat);
        p1 = mq(bi, wi, sat);
        p2 = mq(br, wi, sat);
        p3 = mq(bi, wr, sat);
        tr = conj ? p0 + p1 : p0 - p1;
        ti = conj ? p3 - p2 : p2 + p3;
        return {16'(ar + tr), 16'(ai + ti), 16'(ar - tr), 16'(ai - ti)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; expected results go onto the scoreboards
    task automatic drive(input logic [15:0] ar, ai, br, bi, wr, wi);
        int t = 0;
        while (!rdy0 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("ready_wait", 64'(t < 50), 64'd1);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        q0.push_back(bfly(ar, ai, br, bi, wr, wi, 1'b1, 1'b0));
        q1.push_back(bfly(ar, ai, br, bi, wr, wi, 1'b0, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_re = 16'($urandom); a_im = 16'($urandom); b_re = 16'($urandom);
        b_im = 16'($urandom); w_re = 16'($urandom); w_im = 16'($urandom);
    endtask

    // Wait for out_valid (cycle numbering from the handshake) and score both instances
    task automatic collect(input string tag, input int start_cyc);
        int cyc = start_cyc;
        logic [63:0] e0, e1;
        while (!ov0 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, "/latency"}, 64'(cyc), 64'd11);
        check({tag, "/valid1"}, {63'd0, ov1}, 64'd1);
        if (q0.size() == 0 || q1.size() == 0) begin
            check({tag, "/sb_empty"}, 64'(q0.size() + q1.size()), 64'd2);
        end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check({tag, "/dut0"}, {xr0, xi0, yr0, yi0}, e0);
            check({tag, "/dut1"}, {xr1, xi1, yr1, yi1}, e1);
        end
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, "/release"}, {62'd0, rdy0, ov0}, 64'd2);
        end
    endtask

    initial begin
        logic [63:0] snap;
        logic        seen;

        // Reset state
        #1;
        check("reset_state", {rdy0, ov0, rdy1, ov1, mode0, opa0, opb0, opc0, 4'd0},
              {1'b1, 1'b0, 1'b1, 1'b0, `ALUMODE_IDLE, 16'd0, 16'd0, 16'd0, 4'd0});
        check("reset_xy", {xr0, xi0, yr0, yi0}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Truncation case, with a peek at the first ALU step (cycle 5)
        drive(16'd1000, 16'd0, 16'd2000, 16'd0, 16'd32767, 16'd0);
        repeat (4) begin @(posedge clk); #1; end
        check("alu_step0_dut0", {mode0, opa0, opb0, opc0, 12'd0},
              {`ALUMODE_A_SUB_B, 16'd1999, 16'd0, 16'd0, 12'd0});
        check("alu_step0_dut1", {mode1, opa1, 44'd0}, {`ALUMODE_A_ADD_B, 16'd1999, 44'd0});
        collect("trunc", 5);

        // Pure imaginary twiddle, plain and conjugate
        drive(16'd0, 16'd0, 16'd100, 16'd50, 16'd0, 16'h8000);
        collect("imag_tw", 1);

        // -1 * -1 saturation (dut0) vs wrap (dut1)
        drive(16'd0, 16'd0, 16'h8000, 16'd0, 16'h8000, 16'd0);
        collect("sat_wrap", 1);

        // Sum wraps modulo 2^16
        drive(16'd32000, 16'd0, 16'd2000, 16'd0, 16'd32767, 16'd0);
        collect("sum_wrap", 1);

        // Random operands
        for (int k = 0; k < 5; k++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom));
            collect("random", 1);
        end

        // Backpressure: hold for 5 cycles while a new request is offered
        out_ready = 1'b0;
        drive(16'd1234, 16'hFF00, 16'd3000, 16'h9000, 16'd20000, 16'hC000);
        collect("bp", 1);
        snap = {xr0, xi0, yr0, yi0};
        a_re = 16'd7; b_re = 16'd7; w_re = 16'd7;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_out", {xr0, xi0, yr0, yi0}, snap);
            check("bp_hold_ctl", {62'd0, rdy0, ov0}, 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {62'd0, rdy0, ov0}, 64'd2);
        check("bp_xy_kept", {xr0, xi0, yr0, yi0}, snap);

        // Reset mid-operation at cycle 6
        drive(16'd555, 16'd666, 16'd777, 16'd888, 16'd9999, 16'd1111);
        void'(q0.pop_back());
        void'(q1.pop_back());
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort_ctl", {rdy0, ov0, mode0, opa0, opb0, 26'd0},
              {1'b1, 1'b0, `ALUMODE_IDLE, 16'd0, 16'd0, 26'd0});
        check("abort_xy", {xr0, xi0, yr0, yi0}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (ov0 || ov1) seen = 1'b1;
        end
        check("abort_no_valid", {63'd0, seen}, 64'd0);

        drive(16'd1000, 16'd0, 16'd2000, 16'd0, 16'd32767, 16'd0);
        collect("after_abort", 1);

        check("sb_drained", 64'(q0.size() + q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
